// File: rtl/tt_hit_pkg.sv
// Shared hit-word definitions for the layer capture and readout stages.
package tt_hit_pkg;

    localparam int HIT_W = 24;
    localparam int TS_W  = 8;

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [HIT_W-1:0] hit;
    } hit_word_t;

    localparam int WORD_W = $bits(hit_word_t);

endpackage

// File: rtl/hit_fifo.sv
// Generic synchronous first-word-fall-through FIFO with extra-MSB pointers.
module hit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A write into a full FIFO is legal only when the head leaves at the same edge.
    assign w_rd = rd_en && !w_empty;
    assign w_wr = wr_en && (!w_full || w_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign full    = w_full;
    assign empty   = w_empty;
    assign count   = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/layer_hit_buffer.sv
// Per-layer hit capture: timestamps nonzero hits, buffers them, and
// accounts for hits lost to overflow.
import tt_hit_pkg::*;

module layer_hit_buffer #(
    parameter int DEPTH = 16,
    parameter int OVF_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      hit_dv,
    input  logic [HIT_W-1:0]          hit_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TS_W+HIT_W-1:0]     out_data,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [OVF_W-1:0]          ovf_cnt,
    output logic                      ovf
);

    logic [TS_W-1:0]  r_ts_cnt;
    logic [OVF_W-1:0] r_ovf_cnt;
    logic             r_ovf;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_hit_nz;
    logic             w_push;
    logic             w_drop;
    hit_word_t        w_wr_word;
    hit_word_t        w_rd_word;

    assign w_pop    = !w_empty && out_ready;
    assign w_hit_nz = hit_dv && (hit_data != '0);
    assign w_push   = w_hit_nz && (!w_full || w_pop);
    assign w_drop   = w_hit_nz && w_full && !w_pop;

    // Timestamp is the pre-increment value of this edge.
    assign w_wr_word.ts  = r_ts_cnt;
    assign w_wr_word.hit = hit_data;

    hit_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (w_wr_word),
        .full    (w_full),
        .rd_en   (w_pop),
        .rd_data (w_rd_word),
        .empty   (w_empty),
        .count   (occupancy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts_cnt  <= '0;
            r_ovf_cnt <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (en) r_ts_cnt <= r_ts_cnt + 1'b1;
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
            end
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_rd_word;
    assign ovf_cnt   = r_ovf_cnt;
    assign ovf       = r_ovf;

endmodule
